// File: rtl/mem_pkg.sv
// Shared constants and types for the RV32I memory stage.
// Holds load/store funct3 encodings and the wait-state FSM state type.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/data_mem_be.sv
// Byte-enabled data memory: DEPTH_WORDS x 32, combinational read.
// Ports: clk, we, be[3:0] lane enables, addr word index, wdata, rdata.
module data_mem_be #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: sub-word load/store, fault detection, wait states,
// flush and the MEM/WB register. Inputs are the EX/MEM fields plus
// FlushM; outputs are StallM (combinational) and the registered W fields.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int MEM_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    input  logic        FlushM,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic        MisalignW
);

    localparam int         AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    logic        access;
    logic        illegal;
    logic        misal;
    logic        fault;
    logic        valid;
    logic        last;
    logic        mem_we;
    logic [3:0]  be;
    logic [31:0] st_data;
    logic [31:0] rdata;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [1:0]  off;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;

    assign off    = ALUResultM[1:0];
    assign access = MemReadM | MemWriteM;

    // MemWriteM wins over MemReadM, so legality is judged as a store.
    always_comb begin
        illegal = 1'b0;
        misal   = 1'b0;
        case (Funct3M)
            F3_B:  ;
            F3_H:  misal = off[0];
            F3_W:  misal = (off != 2'b00);
            F3_BU: illegal = MemWriteM;
            F3_HU: begin
                illegal = MemWriteM;
                misal   = off[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    assign fault = access & (illegal | misal);
    assign valid = access & ~fault;

    always_comb begin
        be      = 4'b1111;
        st_data = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                be      = 4'b0001 << off;
                st_data = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be      = off[1] ? 4'b1100 : 4'b0011;
                st_data = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    data_mem_be #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_dmem (
        .clk  (clk),
        .we   (mem_we),
        .be   (be),
        .addr (ALUResultM[AW+1:2]),
        .wdata(st_data),
        .rdata(rdata)
    );

    assign ld_byte = rdata[8*off +: 8];
    assign ld_half = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_data = rdata;
        case (Funct3M)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ;
        endcase
    end

    // The completing cycle: always with zero latency, else WAIT at cnt=0.
    assign last   = (LAT == 4'd0) || (state_q == WAIT && cnt_q == 4'd0);
    assign StallM = ~rst & ~FlushM & valid & ~last;
    assign mem_we = ~rst & ~FlushM & valid & MemWriteM & last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (valid && LAT != 4'd0) begin
                    state_d = WAIT;
                    cnt_d   = LAT - 4'd1;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
        if (FlushM) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || FlushM || StallM) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= 32'h0;
            ReadDataW  <= 32'h0;
            PCPlus4W   <= 32'h0;
            RdW        <= 5'd0;
            MisalignW  <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~fault;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (valid & MemReadM & ~MemWriteM) ? ld_data : 32'h0;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            MisalignW  <= fault;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: three instances (latency 0, 3, 2)
// checked against a byte-array reference model with random stimulus.
module tb_mem_stage;

    localparam int DEPTH = 64;
    localparam int NB    = 4 * DEPTH;
    localparam int LATS[3] = '{0, 3, 2};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWriteM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        MemReadM = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic [2:0]  Funct3M = 3'b010;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic [31:0] PCPlus4M = 32'h0;
    logic [4:0]  RdM = 5'd0;
    logic        FlushM = 1'b0;
    logic [1:0]  sel = 2'd0;

    logic        stall_o [3];
    logic        rw_w    [3];
    logic [1:0]  rs_w    [3];
    logic [31:0] alu_w   [3];
    logic [31:0] rdat_w  [3];
    logic [31:0] pc_w    [3];
    logic [4:0]  rdw     [3];
    logic        mis_w   [3];

    logic [7:0]  mm [3][NB];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stage #(
            .DEPTH_WORDS(DEPTH),
            .MEM_LATENCY(LATS[g])
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .RegWriteM (RegWriteM),
            .MemWriteM (MemWriteM && sel == 2'(g)),
            .MemReadM  (MemReadM && sel == 2'(g)),
            .ResultSrcM(ResultSrcM),
            .Funct3M   (Funct3M),
            .ALUResultM(ALUResultM),
            .WriteDataM(WriteDataM),
            .PCPlus4M  (PCPlus4M),
            .RdM       (RdM),
            .FlushM    (FlushM),
            .StallM    (stall_o[g]),
            .RegWriteW (rw_w[g]),
            .ResultSrcW(rs_w[g]),
            .ALUResultW(alu_w[g]),
            .ReadDataW (rdat_w[g]),
            .PCPlus4W  (pc_w[g]),
            .RdW       (rdw[g]),
            .MisalignW (mis_w[g])
        );
    end

    // Access size in bytes for a funct3, 0 when the encoding is illegal.
    function automatic int size_of(input logic [2:0] f3, input logic st);
        case (f3)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd4: return st ? 0 : 1;
            3'd5: return st ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input int k,
                                               input logic [2:0] f3,
                                               input logic [31:0] addr);
        int a;
        logic [15:0] h;
        a = int'(addr % NB);
        h = {mm[k][(a + 1) % NB], mm[k][a]};
        case (f3)
            3'd0: return 32'($signed(mm[k][a]));
            3'd4: return 32'(mm[k][a]);
            3'd1: return 32'($signed(h));
            3'd5: return 32'(h);
            default: return {mm[k][a + 3], mm[k][a + 2], h};
        endcase
    endfunction

    task automatic model_store(input int k, input int size,
                               input logic [31:0] addr,
                               input logic [31:0] wd);
        int a;
        a = int'(addr % NB);
        for (int i = 0; i < size; i++) mm[k][a + i] = wd[8*i +: 8];
    endtask

    task automatic nop();
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        RegWriteM = 1'b0;
    endtask

    // Issue one instruction on DUT k (called at posedge+1), wait until it
    // reaches W, and check stall count, bubbles and every W field.
    task automatic run_op(input int k, input logic mr, input logic mw,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          output logic [31:0] got);
        logic        acc;
        logic        flt;
        logic        s;
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] pc;
        logic [31:0] exp_rd;
        int          size;
        int          exp_st;
        int          stalls;
        int          bad;
        acc    = mr | mw;
        size   = size_of(f3, mw);
        flt    = acc && (size == 0 || (addr % size) != 0);
        exp_st = (acc && !flt) ? LATS[k] : 0;
        exp_rd = 32'h0;
        if (acc && !flt && !mw) exp_rd = model_load(k, f3, addr);
        rw = 1'($urandom_range(0, 1));
        rs = 2'($urandom_range(0, 3));
        pc = $urandom;
        sel = 2'(k);
        MemReadM = mr; MemWriteM = mw; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; RdM = rd;
        RegWriteM = rw; ResultSrcM = rs; PCPlus4M = pc;
        #1;
        stalls = 0;
        bad = 0;
        s = stall_o[k];
        while (s && stalls < 40) begin
            @(posedge clk); #1;
            stalls++;
            if (rw_w[k] !== 1'b0 || rdw[k] !== 5'd0 || mis_w[k] !== 1'b0)
                bad++;
            s = stall_o[k];
        end
        @(posedge clk); #1;
        if (mw && !flt) model_store(k, size, addr, wd);
        checks++;
        if (stalls !== exp_st) begin
            errors++;
            $display("FAIL stall_cycles dut%0d got %0d want %0d", k, stalls, exp_st);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_bubble dut%0d got %0d bad want 0", k, bad);
        end
        checks++;
        if (rw_w[k] !== (rw & ~flt) || mis_w[k] !== flt) begin
            errors++;
            $display("FAIL regwrite_misalign dut%0d got %b/%b want %b/%b",
                     k, rw_w[k], mis_w[k], rw & ~flt, flt);
        end
        checks++;
        if (rdw[k] !== rd || rs_w[k] !== rs || alu_w[k] !== addr || pc_w[k] !== pc) begin
            errors++;
            $display("FAIL passthru dut%0d got %h/%h/%h/%h want %h/%h/%h/%h",
                     k, rdw[k], rs_w[k], alu_w[k], pc_w[k], rd, rs, addr, pc);
        end
        if (!(acc && (flt || mw))) begin
            checks++;
            if (rdat_w[k] !== exp_rd) begin
                errors++;
                $display("FAIL readdata dut%0d f3=%0d addr=%h got %h want %h",
                         k, f3, addr, rdat_w[k], exp_rd);
            end
        end
        got = rdat_w[k];
        nop();
    endtask

    task automatic test_reset();
        sel = 2'd1;
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h4;
        RegWriteM = 1'b1; RdM = 5'd7; PCPlus4M = 32'h44;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (stall_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got %b want 0", stall_o[1]);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({rw_w[k], rs_w[k], alu_w[k], rdat_w[k], pc_w[k], rdw[k], mis_w[k]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got rw=%b rd=%h alu=%h want 0",
                         k, rw_w[k], rdw[k], alu_w[k]);
            end
        end
        nop();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_preload();
        logic [31:0] d;
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < DEPTH; w++)
                run_op(k, 1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, 5'd0, d);
    endtask

    task automatic test_subword();
        logic [31:0] d;
        run_op(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, d);
        run_op(0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 5'd2, d);
        checks++;
        if (d !== 32'hFFFFFFDE) begin
            errors++;
            $display("FAIL lb_0x13 got %h want FFFFFFDE", d);
        end
        run_op(0, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 5'd3, d);
        checks++;
        if (d !== 32'h000000DE) begin
            errors++;
            $display("FAIL lbu_0x13 got %h want 000000DE", d);
        end
        run_op(0, 1'b0, 1'b1, 3'b010, 32'h20, 32'hAABBCCDD, 5'd0, d);
        run_op(0, 1'b0, 1'b1, 3'b001, 32'h22, 32'h55661234, 5'd0, d);
        run_op(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd4, d);
        checks++;
        if (d !== 32'h1234CCDD) begin
            errors++;
            $display("FAIL lw_after_sh got %h want 1234CCDD", d);
        end
        run_op(0, 1'b1, 1'b0, 3'b001, 32'h22, 32'h0, 5'd5, d);
        checks++;
        if (d !== 32'h00001234) begin
            errors++;
            $display("FAIL lh_0x22 got %h want 00001234", d);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] d;
        for (int k = 0; k < 2; k++) begin
            run_op(k, 1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 5'd9, d);
            run_op(k, 1'b0, 1'b1, 3'b010, 32'h6, 32'h12345678, 5'd0, d);
            run_op(k, 1'b0, 1'b1, 3'b101, 32'h4, 32'h12345678, 5'd0, d);
            run_op(k, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 5'd9, d);
            run_op(k, 1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 5'd9, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        run_op(1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 5'd10, d);
        run_op(1, 1'b0, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 5'd0, d);
        run_op(1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 5'd11, d);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL b2b_readback got %h want CAFEF00D", d);
        end
    endtask

    // Store on the latency-2 DUT, flushed during cycle n of its life.
    task automatic test_flush(input int n);
        logic [31:0] d;
        sel = 2'd2;
        MemWriteM = 1'b1; MemReadM = 1'b0; Funct3M = 3'b010;
        ALUResultM = 32'h40; WriteDataM = $urandom; RdM = 5'd12;
        RegWriteM = 1'b1;
        #1;
        for (int c = 1; c < n; c++) begin
            @(posedge clk); #1;
        end
        FlushM = 1'b1;
        @(posedge clk); #1;
        FlushM = 1'b0;
        nop();
        checks++;
        if (rw_w[2] !== 1'b0 || rdw[2] !== 5'd0 || mis_w[2] !== 1'b0 || alu_w[2] !== 32'h0) begin
            errors++;
            $display("FAIL flush_bubble n=%0d got rw=%b rd=%h alu=%h want 0",
                     n, rw_w[2], rdw[2], alu_w[2]);
        end
        #1;
        checks++;
        if (stall_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle n=%0d got stall %b want 0", n, stall_o[2]);
        end
        @(posedge clk); #1;
        run_op(2, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd13, d);
    endtask

    task automatic test_reset_wait();
        logic [31:0] d;
        sel = 2'd1;
        MemWriteM = 1'b1; MemReadM = 1'b0; Funct3M = 3'b010;
        ALUResultM = 32'h50; WriteDataM = $urandom; RdM = 5'd14;
        RegWriteM = 1'b1; PCPlus4M = 32'h1234;
        #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (stall_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_stall got %b want 0", stall_o[1]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        nop();
        checks++;
        if ({rw_w[1], rs_w[1], alu_w[1], rdat_w[1], pc_w[1], rdw[1], mis_w[1]} !== '0) begin
            errors++;
            $display("FAIL rst_wait_outputs got rw=%b rd=%h pc=%h want 0",
                     rw_w[1], rdw[1], pc_w[1]);
        end
        run_op(1, 1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 5'd15, d);
    endtask

    task automatic test_alias();
        logic [31:0] d;
        for (int k = 0; k < 3; k++) begin
            run_op(k, 1'b0, 1'b1, 3'b010, 32'(NB + 8), 32'h0BADF00D + 32'(k), 5'd0, d);
            run_op(k, 1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 5'd16, d);
            checks++;
            if (d !== 32'h0BADF00D + 32'(k)) begin
                errors++;
                $display("FAIL alias dut%0d got %h want %h", k, d, 32'h0BADF00D + 32'(k));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        int          r;
        int          sz;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 80; i++) begin
                r  = int'($urandom_range(0, 9));
                mr = (r <= 3) || (r == 7);
                mw = (r >= 4) && (r <= 7);
                if ($urandom_range(0, 9) < 7) begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'd0;
                        1: f3 = 3'd1;
                        2: f3 = 3'd2;
                        3: f3 = 3'd4;
                        default: f3 = 3'd5;
                    endcase
                end else begin
                    f3 = 3'($urandom_range(0, 7));
                end
                addr = 32'($urandom_range(0, 2 * NB - 1));
                sz = size_of(f3, mw);
                if (sz != 0 && $urandom_range(0, 1) == 1) addr = addr & ~32'(sz - 1);
                if ($urandom_range(0, 7) == 0) addr = addr | 32'h8000_0000;
                run_op(k, mr, mw, f3, addr, $urandom, 5'($urandom_range(0, 31)), d);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_preload();
        test_subword();
        test_misalign();
        test_back_to_back();
        test_flush(2);
        test_flush(3);
        test_reset_wait();
        test_alias();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
